// File: rtl/dt_pkg.sv
// Shared constants for the distance-transform pipeline and ridge stage.
// Image geometry, bus widths and ridge FSM state encodings.
package dt_pkg;

  localparam int IMG_W       = 128;
  localparam int PACK_W      = 16;
  localparam int PIX_W       = 8;
  localparam int ADDR_W      = 14;
  localparam int SKEL_ADDR_W = 10;
  localparam int CNT_W       = 14;
  localparam int IDX_W       = $clog2(IMG_W);
  localparam int PACK_LG     = $clog2(PACK_W);

  // last column/row index, and the last processed row (one before)
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(IMG_W - 1);
  localparam logic [IDX_W-1:0] IDX_PEN = IDX_W'(IMG_W - 2);

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] RS_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] RS_CLR   = 3'd1;
  localparam logic [ST_W-1:0] RS_PRIME = 3'd2;
  localparam logic [ST_W-1:0] RS_FETCH = 3'd3;
  localparam logic [ST_W-1:0] RS_EVAL  = 3'd4;
  localparam logic [ST_W-1:0] RS_WR    = 3'd5;
  localparam logic [ST_W-1:0] RS_DONE  = 3'd6;

endpackage

// File: rtl/dt_win3x3.sv
// 3x3 sliding window over distance values with ridge comparator.
// Ports: clk, rst_ni (sync, active-low), clr_i, shift_i,
//   n_i/c_i/s_i new column (top/mid/bottom), ridge_o, centre_o.
// The right column is the live n_i/c_i/s_i input, not a register,
// so the centre is evaluated in the same cycle the column arrives.
module dt_win3x3
  import dt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic [PIX_W-1:0] n_i,
  input  logic [PIX_W-1:0] c_i,
  input  logic [PIX_W-1:0] s_i,
  output logic             ridge_o,
  output logic [PIX_W-1:0] centre_o
);

  // index 0 = north, 1 = centre row, 2 = south
  logic [2:0][PIX_W-1:0] l_q;
  logic [2:0][PIX_W-1:0] m_q;

  always_ff @(posedge clk) begin
    if (!rst_ni || clr_i) begin
      l_q <= '0;
      m_q <= '0;
    end else if (shift_i) begin
      l_q <= m_q;
      m_q <= {s_i, c_i, n_i};
    end
  end

  assign centre_o = m_q[1];

  assign ridge_o = (centre_o != '0)
                && (centre_o >= l_q[0])
                && (centre_o >= l_q[1])
                && (centre_o >= l_q[2])
                && (centre_o >= m_q[0])
                && (centre_o >= m_q[2])
                && (centre_o >= n_i)
                && (centre_o >= c_i)
                && (centre_o >= s_i);

endmodule

// File: rtl/dt_ridge_extract.sv
// Ridge (medial-axis) extraction over the 128x128 distance map.
// Ports: clk, reset (sync, active-low), start; result RAM read
//   res_rd/res_addr/res_di; skeleton write skel_wr/skel_addr/skel_do;
//   ridge_cnt, done; max_val/max_addr when DT_RIDGE_MAX_TRACK_EN.
module dt_ridge_extract
  import dt_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   res_rd,
  output logic [ADDR_W-1:0]      res_addr,
  input  logic [PIX_W-1:0]       res_di,
  output logic                   skel_wr,
  output logic [SKEL_ADDR_W-1:0] skel_addr,
  output logic [PACK_W-1:0]      skel_do,
  output logic [CNT_W-1:0]       ridge_cnt,
  output logic                   done
`ifdef DT_RIDGE_MAX_TRACK_EN
  ,
  output logic [PIX_W-1:0]       max_val,
  output logic [ADDR_W-1:0]      max_addr
`endif
);

  logic [ST_W-1:0]   state_q, state_d;
  logic [IDX_W-1:0]  row_q, col_q;
  logic [IDX_W-1:0]  rd_row, col_nx;
  logic [1:0]        ph_q;
  logic [3:0]        clr_q;
  logic [PIX_W-1:0]  fn_q, fc_q;
  logic [PACK_W-1:0] pack_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              win_clr, win_shift;
  logic              ridge, col_end, accept;
  logic [PIX_W-1:0]  centre;
  logic [PIX_W-1:0]  new_n, new_c, new_s;

  // ph 0/1/2 reads rows r-1/r/r+1
  assign rd_row  = row_q - IDX_W'(1) + IDX_W'(ph_q);
  assign col_nx  = col_q + IDX_W'(1);
  assign col_end = (col_q == IDX_MAX);
  assign accept  = start
                && (state_q == RS_IDLE || state_q == RS_DONE);

  // south sample is taken straight off the RAM bus
  assign new_n = col_end ? '0 : fn_q;
  assign new_c = col_end ? '0 : fc_q;
  assign new_s = col_end ? '0 : res_di;

  dt_win3x3 u_win (
    .clk      (clk),
    .rst_ni   (reset),
    .clr_i    (win_clr),
    .shift_i  (win_shift),
    .n_i      (new_n),
    .c_i      (new_c),
    .s_i      (new_s),
    .ridge_o  (ridge),
    .centre_o (centre)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= RS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RS_IDLE, RS_DONE:
        if (start) state_d = RS_CLR;
      RS_CLR:
        if (clr_q == 4'd15) state_d = RS_PRIME;
      RS_PRIME:
        if (ph_q == 2'd3) state_d = RS_FETCH;
      RS_FETCH:
        if (ph_q == 2'd2) state_d = RS_EVAL;
      RS_EVAL: begin
        if (col_q[PACK_LG-1:0] == '1)
          state_d = RS_WR;
        else if (col_q == IDX_PEN)
          state_d = RS_EVAL;
        else
          state_d = RS_FETCH;
      end
      RS_WR: begin
        if (!col_end)
          state_d = RS_FETCH;
        else if (row_q == IDX_PEN)
          state_d = RS_DONE;
        else
          state_d = RS_PRIME;
      end
      default: state_d = RS_IDLE;
    endcase
  end

  always_comb begin
    res_rd    = 1'b0;
    res_addr  = '0;
    skel_wr   = 1'b0;
    skel_addr = '0;
    skel_do   = '0;
    win_clr   = 1'b0;
    win_shift = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      RS_CLR: begin
        // rows 0 and 127 are never evaluated
        skel_wr   = 1'b1;
        skel_addr = {{IDX_W{clr_q[3]}}, clr_q[2:0]};
      end
      RS_PRIME: begin
        win_clr   = (ph_q == 2'd0);
        win_shift = (ph_q == 2'd3);
        if (ph_q != 2'd3) begin
          res_rd   = 1'b1;
          res_addr = {rd_row, {IDX_W{1'b0}}};
        end
      end
      RS_FETCH: begin
        res_rd   = 1'b1;
        res_addr = {rd_row, col_nx};
      end
      RS_EVAL:
        win_shift = 1'b1;
      RS_WR: begin
        skel_wr   = 1'b1;
        skel_addr = {row_q, col_q[IDX_W-1:PACK_LG]};
        skel_do   = pack_q;
      end
      RS_DONE:
        done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_q  <= '0;
      col_q  <= '0;
      ph_q   <= '0;
      clr_q  <= '0;
      fn_q   <= '0;
      fc_q   <= '0;
      pack_q <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (state_q)
        RS_IDLE, RS_DONE:
          if (start) begin
            clr_q <= '0;
            cnt_q <= '0;
          end
        RS_CLR: begin
          clr_q <= clr_q + 4'd1;
          row_q <= IDX_W'(1);
          col_q <= '0;
          ph_q  <= '0;
        end
        RS_PRIME, RS_FETCH: begin
          if (state_d != state_q) ph_q <= '0;
          else                    ph_q <= ph_q + 2'd1;
          if (ph_q == 2'd1) fn_q <= res_di;
          if (ph_q == 2'd2) fc_q <= res_di;
        end
        RS_EVAL: begin
          pack_q <= {pack_q[PACK_W-2:0], ridge};
          if (ridge && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
          if (col_q[PACK_LG-1:0] != '1)
            col_q <= col_nx;
        end
        RS_WR: begin
          col_q <= col_nx;
          if (col_end) row_q <= row_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ridge_cnt = cnt_q;

`ifdef DT_RIDGE_MAX_TRACK_EN
  logic [PIX_W-1:0]  max_val_q;
  logic [ADDR_W-1:0] max_addr_q;

  // strict compare keeps the first raster occurrence
  always_ff @(posedge clk) begin
    if (!reset || accept) begin
      max_val_q  <= '0;
      max_addr_q <= '0;
    end else if (state_q == RS_EVAL
              && centre > max_val_q) begin
      max_val_q  <= centre;
      max_addr_q <= {row_q, col_q};
    end
  end

  assign max_val  = max_val_q;
  assign max_addr = max_addr_q;
`else
  logic unused_max;
  assign unused_max = ^{centre, accept};
`endif

endmodule

// File: tb/tb_dt_ridge_extract.sv
// Directed bench for dt_ridge_extract: reset, mid-scan abort,
// busy start, full scan of a composite map, restart clearing.
`timescale 1ns/1ps
module tb_dt_ridge_extract;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di = '0;
  logic        skel_wr;
  logic [9:0]  skel_addr;
  logic [15:0] skel_do;
  logic [13:0] ridge_cnt;
  logic        done;
`ifdef DT_RIDGE_MAX_TRACK_EN
  logic [7:0]  max_val;
  logic [13:0] max_addr;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int run_id = 0;
  int overlaps   = 0;
  int done_rises = 0;
  logic done_d = 1'b0;

  logic [7:0]  rmem  [16384];
  logic [15:0] smem  [1024];
  int          wrun  [1024];
  logic [15:0] exp_w [1024];

  dt_ridge_extract dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .res_rd    (res_rd),
    .res_addr  (res_addr),
    .res_di    (res_di),
    .skel_wr   (skel_wr),
    .skel_addr (skel_addr),
    .skel_do   (skel_do),
    .ridge_cnt (ridge_cnt),
    .done      (done)
`ifdef DT_RIDGE_MAX_TRACK_EN
    ,
    .max_val   (max_val),
    .max_addr  (max_addr)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (res_rd) res_di <= rmem[res_addr];
    if (skel_wr) begin
      smem[skel_addr] <= skel_do;
      wrun[skel_addr] <= run_id;
    end
    if (reset && res_rd && skel_wr)
      overlaps <= overlaps + 1;
    if (done && !done_d)
      done_rises <= done_rises + 1;
    done_d <= done;
  end

  function automatic int adr(int r, int c);
    return r * 128 + c;
  endfunction

  task automatic load_map();
    for (int i = 0; i < 16384; i++) rmem[i] = 8'd0;
    rmem[adr(5, 5)] = 8'd9;
    rmem[adr(7, 3)] = 8'd9;
    for (int r = 10; r <= 12; r++)
      for (int c = 20; c <= 22; c++)
        rmem[adr(r, c)] = 8'd1;
    rmem[adr(11, 21)] = 8'd2;
    for (int c = 0; c < 128; c++) begin
      rmem[adr(40, c)] = 8'd1;
      rmem[adr(41, c)] = 8'd1;
    end
    rmem[adr(126, 127)] = 8'd5;
    for (int i = 0; i < 1024; i++) begin
      exp_w[i] = 16'h0000;
      wrun[i]  = 0;
    end
    exp_w[40]   = 16'h0400;
    exp_w[56]   = 16'h1000;
    exp_w[89]   = 16'h0400;
    for (int i = 320; i <= 335; i++)
      exp_w[i] = 16'hFFFF;
    exp_w[1015] = 16'h0001;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({res_rd, skel_wr, done} !== 3'b000)
      $display("FAIL rst_ctl got=%b want=000",
               {res_rd, skel_wr, done});
    else n_pass++;
    n_chk++;
    if ({res_addr, skel_addr} !== 24'h0)
      $display("FAIL rst_addr got=%h want=0",
               {res_addr, skel_addr});
    else n_pass++;
    n_chk++;
    if ({skel_do, ridge_cnt} !== 30'h0)
      $display("FAIL rst_data got=%h want=0",
               {skel_do, ridge_cnt});
    else n_pass++;
`ifdef DT_RIDGE_MAX_TRACK_EN
    n_chk++;
    if ({max_val, max_addr} !== 22'h0)
      $display("FAIL rst_max got=%h want=0",
               {max_val, max_addr});
    else n_pass++;
`endif
    reset = 1'b1;
  endtask

  task automatic test_abort_busy();
    int cyc = 0;
    run_id = 1;
    pulse_start();
    // first read of (21,64) happens while row 20 is centre
    while (!(res_rd && res_addr == 14'h0AC0)
           && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    n_chk++;
    if (cyc >= 20000)
      $display("FAIL abort_wait got=timeout want=row20");
    else n_pass++;
    n_chk++;
    if (ridge_cnt !== 14'd3)
      $display("FAIL cnt_row20 got=%0d want=3", ridge_cnt);
    else n_pass++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if ({skel_wr, done} !== 2'b00 || ridge_cnt !== 14'd3)
      $display("FAIL busy_start got=%b/%0d want=00/3",
               {skel_wr, done}, ridge_cnt);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({res_rd, skel_wr, done, ridge_cnt} !== 17'h0)
      $display("FAIL abort_out got=%h want=0",
               {res_rd, skel_wr, done, ridge_cnt});
    else n_pass++;
    n_chk++;
    if ({res_addr, skel_addr, skel_do} !== 40'h0)
      $display("FAIL abort_bus got=%h want=0",
               {res_addr, skel_addr, skel_do});
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    // an idle FSM stays quiet with start low
    n_chk++;
    if ({res_rd, skel_wr} !== 2'b00)
      $display("FAIL abort_idle got=%b want=00",
               {res_rd, skel_wr});
    else n_pass++;
  endtask

  task automatic test_full_scan();
    int cyc = 0;
    int rises0;
    run_id = 2;
    rises0 = done_rises;
    pulse_start();
    while (!done && cyc < 70000) begin
      @(negedge clk);
      cyc++;
    end
    n_chk++;
    if (cyc > 66000)
      $display("FAIL latency got=%0d want<=66000", cyc);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({done, res_rd, skel_wr} !== 3'b100)
      $display("FAIL done_lvl got=%b want=100",
               {done, res_rd, skel_wr});
    else n_pass++;
    n_chk++;
    if (ridge_cnt !== 14'd260)
      $display("FAIL ridge_cnt got=%0d want=260", ridge_cnt);
    else n_pass++;
    n_chk++;
    if (done_rises - rises0 != 1)
      $display("FAIL done_rise got=%0d want=1",
               done_rises - rises0);
    else n_pass++;
    n_chk++;
    if (overlaps != 0)
      $display("FAIL rd_wr_overlap got=%0d want=0", overlaps);
    else n_pass++;
    for (int i = 0; i < 1024; i++) begin
      n_chk++;
      if (wrun[i] != run_id || smem[i] !== exp_w[i])
        $display("FAIL word%0d got=%h(run%0d) want=%h",
                 i, smem[i], wrun[i], exp_w[i]);
      else n_pass++;
    end
`ifdef DT_RIDGE_MAX_TRACK_EN
    n_chk++;
    if (max_val !== 8'd9)
      $display("FAIL max_val got=%0d want=9", max_val);
    else n_pass++;
    n_chk++;
    if (max_addr !== 14'h0285)
      $display("FAIL max_addr got=%h want=0285", max_addr);
    else n_pass++;
`endif
  endtask

  task automatic test_restart_clears();
    pulse_start();
    n_chk++;
    if ({done, ridge_cnt} !== 15'h0)
      $display("FAIL restart_clr got=%b/%0d want=0/0",
               done, ridge_cnt);
    else n_pass++;
`ifdef DT_RIDGE_MAX_TRACK_EN
    n_chk++;
    if ({max_val, max_addr} !== 22'h0)
      $display("FAIL restart_max got=%h want=0",
               {max_val, max_addr});
    else n_pass++;
`endif
    // CLR follows start: row 0 word 1 on the second cycle
    @(negedge clk);
    n_chk++;
    if ({skel_wr, skel_addr, skel_do} !== {1'b1, 10'd1, 16'h0})
      $display("FAIL restart_clr_wr got=%b/%0d/%h want=1/1/0",
               skel_wr, skel_addr, skel_do);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    load_map();
    test_reset();
    test_abort_busy();
    test_full_scan();
    test_restart_clears();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
